// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter
// Shares one UART transmit byte interface (tx_data / write strobe / busy) between
// NUM_REQ byte producers. Round-robin arbitration picks an owner in IDLE. The owner
// may keep its grant for a locked multi-byte message of up to MAX_BURST bytes. Each
// byte is issued, then the block waits for busy to rise and then to fall. If busy
// never rises within BUSY_WAIT_MAX cycles, the byte is abandoned with a timeout pulse.

module uart_tx_arbiter #(
    parameter int NUM_REQ       = 4,
    parameter int BUSY_WAIT_MAX = 16,
    parameter int MAX_BURST     = 16
) (
    input  logic                   clk_i,
    input  logic                   reset_i,
    input  logic                   enable_i,
    input  logic [NUM_REQ-1:0]     req_valid_i,
    input  logic [NUM_REQ*8-1:0]   req_data_i,
    input  logic [NUM_REQ-1:0]     req_lock_i,
    output logic [NUM_REQ-1:0]     req_ready_o,
    output logic [NUM_REQ-1:0]     grant_o,
    output logic [7:0]             tx_data_o,
    output logic                   tx_data_write_en_o,
    input  logic                   tx_busy_i,
    output logic                   active_o,
    output logic                   timeout_o
);

    localparam int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int WAIT_W  = $clog2(BUSY_WAIT_MAX + 1);
    localparam int BURST_W = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;

    localparam logic [IDX_W-1:0]   LAST_IDX   = IDX_W'(NUM_REQ - 1);
    localparam logic [WAIT_W-1:0]  WAIT_LAST  = WAIT_W'(BUSY_WAIT_MAX - 1);
    localparam logic [BURST_W-1:0] BURST_LAST = BURST_W'(MAX_BURST - 1);

    localparam logic [1:0] ST_IDLE      = 2'd0;
    localparam logic [1:0] ST_ISSUE     = 2'd1;
    localparam logic [1:0] ST_WAIT_BUSY = 2'd2;
    localparam logic [1:0] ST_WAIT_DONE = 2'd3;

    logic [1:0]         state_q,     state_d;
    logic [IDX_W-1:0]   rr_ptr_q,    rr_ptr_d;
    logic [IDX_W-1:0]   gnt_idx_q,   gnt_idx_d;
    logic [BURST_W-1:0] burst_cnt_q, burst_cnt_d;
    logic [WAIT_W-1:0]  wait_cnt_q,  wait_cnt_d;
    logic [7:0]         tx_data_q,   tx_data_d;

    logic [IDX_W-1:0]   pick_idx;
    logic [IDX_W-1:0]   gnt_next_ptr;
    logic [NUM_REQ-1:0] gnt_onehot;
    logic               busy_timeout;
    logic               byte_done;
    logic               burst_continue;
    logic               can_start;

    // First requester with valid set, scanning upward from ptr and wrapping at NUM_REQ.
    function automatic logic [IDX_W-1:0] rr_pick(input logic [NUM_REQ-1:0] valid,
                                                 input logic [IDX_W-1:0]   ptr);
        logic [IDX_W-1:0] idx;
        logic [IDX_W-1:0] res;
        logic             found;
        idx   = ptr;
        res   = ptr;
        found = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!found && valid[idx]) begin
                found = 1'b1;
                res   = idx;
            end
            idx = (idx == LAST_IDX) ? '0 : idx + IDX_W'(1);
        end
        return res;
    endfunction

    // Arbitration result, byte-completion conditions and burst continuation decode.
    always_comb begin
        pick_idx       = rr_pick(req_valid_i, rr_ptr_q);
        gnt_next_ptr   = (gnt_idx_q == LAST_IDX) ? '0 : gnt_idx_q + IDX_W'(1);
        can_start      = enable_i && (|req_valid_i) && !tx_busy_i;
        busy_timeout   = (state_q == ST_WAIT_BUSY) && !tx_busy_i && (wait_cnt_q == WAIT_LAST);
        byte_done      = busy_timeout || ((state_q == ST_WAIT_DONE) && !tx_busy_i);
        burst_continue = req_lock_i[gnt_idx_q] && req_valid_i[gnt_idx_q] &&
                         (burst_cnt_q < BURST_LAST);
    end

    // Next-state logic for the byte sequencer.
    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        gnt_idx_d   = gnt_idx_q;
        burst_cnt_d = burst_cnt_q;
        wait_cnt_d  = wait_cnt_q;
        tx_data_d   = tx_data_q;

        case (state_q)
            ST_IDLE: begin
                if (can_start) begin
                    gnt_idx_d   = pick_idx;
                    tx_data_d   = req_data_i[{pick_idx, 3'b000} +: 8];
                    burst_cnt_d = '0;
                    state_d     = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                wait_cnt_d = '0;
                state_d    = ST_WAIT_BUSY;
            end
            ST_WAIT_BUSY: begin
                if (tx_busy_i) begin
                    state_d = ST_WAIT_DONE;
                end else if (!busy_timeout) begin
                    wait_cnt_d = wait_cnt_q + WAIT_W'(1);
                end
            end
            ST_WAIT_DONE: begin
                state_d = ST_WAIT_DONE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // A finished (or abandoned) byte either continues the locked message or
        // releases the grant and moves the round-robin pointer past the owner.
        if (byte_done) begin
            if (burst_continue) begin
                tx_data_d   = req_data_i[{gnt_idx_q, 3'b000} +: 8];
                burst_cnt_d = burst_cnt_q + BURST_W'(1);
                state_d     = ST_ISSUE;
            end else begin
                rr_ptr_d = gnt_next_ptr;
                state_d  = ST_IDLE;
            end
        end
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q     <= ST_IDLE;
            rr_ptr_q    <= '0;
            gnt_idx_q   <= '0;
            burst_cnt_q <= '0;
            wait_cnt_q  <= '0;
            tx_data_q   <= 8'h00;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            gnt_idx_q   <= gnt_idx_d;
            burst_cnt_q <= burst_cnt_d;
            wait_cnt_q  <= wait_cnt_d;
            tx_data_q   <= tx_data_d;
        end
    end

    // Output decode from the registered state; timeout is the abandon condition itself.
    always_comb begin
        gnt_onehot         = NUM_REQ'(1) << gnt_idx_q;
        active_o           = (state_q != ST_IDLE);
        grant_o            = active_o ? gnt_onehot : '0;
        tx_data_write_en_o = (state_q == ST_ISSUE);
        req_ready_o        = tx_data_write_en_o ? gnt_onehot : '0;
        timeout_o          = busy_timeout;
        tx_data_o          = tx_data_q;
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: directed producer streams, a simple UART busy
// model, and a monitor that checks every write strobe against queued expectations.

module tb_uart_tx_arbiter;

    localparam int NR = 4;

    logic          clk = 1'b0;
    logic          reset_i, enable_i, tx_busy_i;
    logic [NR-1:0] req_valid_i, req_lock_i, req_ready_o, grant_o;
    logic [NR*8-1:0] req_data_i;
    logic [7:0]    tx_data_o;
    logic          tx_data_write_en_o, active_o, timeout_o;

    always #5 clk = ~clk;

    uart_tx_arbiter #(.NUM_REQ(NR), .BUSY_WAIT_MAX(16), .MAX_BURST(16)) dut (
        .clk_i(clk), .reset_i(reset_i), .enable_i(enable_i),
        .req_valid_i(req_valid_i), .req_data_i(req_data_i), .req_lock_i(req_lock_i),
        .req_ready_o(req_ready_o), .grant_o(grant_o), .tx_data_o(tx_data_o),
        .tx_data_write_en_o(tx_data_write_en_o), .tx_busy_i(tx_busy_i),
        .active_o(active_o), .timeout_o(timeout_o)
    );

    typedef struct { int idx; logic [7:0] data; } exp_t;

    exp_t       sbq[$];
    int         scq[$];
    int         toq[$];
    int         checks = 0;
    int         errors = 0;
    int         nstrobe = 0;
    int         cyc = 0;
    logic [7:0] pmem [NR][64];
    int         phead [NR];
    int         ptail [NR];
    bit         uart_dead, busy_force;
    int         uart_len, ucnt;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic feed(input int k, input logic [7:0] d);
        pmem[k][ptail[k] % 64] = d;
        ptail[k]++;
    endtask

    task automatic expect_byte(input int k, input logic [7:0] d);
        exp_t e;
        e.idx  = k;
        e.data = d;
        sbq.push_back(e);
    endtask

    function automatic bit all_empty();
        for (int k = 0; k < NR; k++) if (phead[k] != ptail[k]) return 1'b0;
        return 1'b1;
    endfunction

    task automatic wait_idle(input string name, input int budget);
        bit done = 1'b0;
        for (int n = 0; n < budget && !done; n++) begin
            step(1);
            done = !active_o && (sbq.size() == 0) && all_empty();
        end
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL %s: idle not reached within %0d cycles (pending=%0d)", name, budget, sbq.size());
        end
    endtask

    task automatic wait_strobe(input string name, input int budget);
        bit seen = 1'b0;
        for (int n = 0; n < budget && !seen; n++) begin
            step(1);
            seen = tx_data_write_en_o;
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL %s: no write strobe within %0d cycles", name, budget);
        end
    endtask

    task automatic chk_all_zero(input string name);
        chk({name, "_active"}, 32'(active_o), 32'd0);
        chk({name, "_grant"}, 32'(grant_o), 32'd0);
        chk({name, "_ready"}, 32'(req_ready_o), 32'd0);
        chk({name, "_wr_en"}, 32'(tx_data_write_en_o), 32'd0);
        chk({name, "_timeout"}, 32'(timeout_o), 32'd0);
        chk({name, "_tx_data"}, 32'(tx_data_o), 32'd0);
    endtask

    // Producers and UART busy model, updated on the falling edge.
    initial begin
        req_valid_i = '0;
        req_data_i  = '0;
        tx_busy_i   = 1'b0;
        ucnt        = 0;
        for (int k = 0; k < NR; k++) begin
            phead[k] = 0;
            ptail[k] = 0;
        end
        forever begin
            @(negedge clk);
            for (int k = 0; k < NR; k++)
                if (req_ready_o[k] && phead[k] != ptail[k]) phead[k]++;
            if (tx_data_write_en_o && !uart_dead) ucnt = uart_len;
            tx_busy_i = busy_force || (ucnt > 0);
            if (ucnt > 0) ucnt--;
            for (int k = 0; k < NR; k++) begin
                req_valid_i[k]       = (phead[k] != ptail[k]);
                req_data_i[8*k +: 8] = req_valid_i[k] ? pmem[k][phead[k] % 64] : 8'h00;
            end
        end
    end

    // Monitor: every strobe pops one expectation; ready must be silent otherwise.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (tx_data_write_en_o) begin
                nstrobe++;
                scq.push_back(cyc);
                if (sbq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_strobe: got data %0h ready %0b expected no strobe", tx_data_o, req_ready_o);
                end else begin
                    e = sbq.pop_front();
                    chk("sb_ready", 32'(req_ready_o), 32'(1) << e.idx);
                    chk("sb_grant", 32'(grant_o), 32'(1) << e.idx);
                    chk("sb_data", 32'(tx_data_o), 32'(e.data));
                end
            end else begin
                chk("ready_idle", 32'(req_ready_o), 32'd0);
            end
            if (timeout_o) toq.push_back(cyc);
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n0;
        reset_i    = 1'b1;
        enable_i   = 1'b1;
        req_lock_i = '0;
        uart_dead  = 1'b0;
        busy_force = 1'b0;
        uart_len   = 3;
        step(3);
        chk_all_zero("reset");
        reset_i = 1'b0;
        step(2);

        // Single byte, one-cycle latency, then round-robin pointer moved to 1.
        feed(0, 8'h41);
        expect_byte(0, 8'h41);
        step(1);
        chk("t1_no_strobe_yet", 32'(tx_data_write_en_o), 32'd0);
        step(1);
        chk("t1_strobe_latency", 32'(tx_data_write_en_o), 32'd1);
        wait_idle("t1", 50);
        chk("t1_data_hold", 32'(tx_data_o), 32'h41);
        feed(0, 8'h50);
        feed(1, 8'h51);
        expect_byte(1, 8'h51);
        expect_byte(0, 8'h50);
        wait_idle("t1_rr", 50);

        reset_i = 1'b1;
        step(1);
        reset_i = 1'b0;
        step(1);

        // Round-robin over all requesters, two passes (wrap 3 -> 0).
        scq.delete();
        for (int r = 0; r < 2; r++)
            for (int k = 0; k < NR; k++) begin
                feed(k, 8'(8'h10 * (k + 1) + r));
                expect_byte(k, 8'(8'h10 * (k + 1) + r));
            end
        wait_idle("t2", 200);
        chk("t2_strobes", 32'(scq.size()), 32'd8);
        chk("t2_gap_0_1", 32'(scq[1] - scq[0]), 32'd5);
        chk("t2_gap_wrap", 32'(scq[4] - scq[3]), 32'd5);

        // Locked burst capped at 16 bytes, then req2, then req1 resumes.
        scq.delete();
        req_lock_i = 4'b0010;
        for (int i = 0; i < 20; i++) feed(1, 8'(8'h40 + i));
        feed(2, 8'hC2);
        for (int i = 0; i < 16; i++) expect_byte(1, 8'(8'h40 + i));
        expect_byte(2, 8'hC2);
        for (int i = 16; i < 20; i++) expect_byte(1, 8'(8'h40 + i));
        wait_idle("t3", 400);
        req_lock_i = '0;
        chk("t3_strobes", 32'(scq.size()), 32'd21);
        chk("t3_locked_gap", 32'(scq[1] - scq[0]), 32'd4);
        chk("t3_release_gap", 32'(scq[16] - scq[15]), 32'd5);
        chk("t3_resume_gap", 32'(scq[17] - scq[16]), 32'd5);
        chk("t3_no_timeout", 32'(toq.size()), 32'd0);

        // Busy never rises: timeout 16 cycles after each strobe, next requester served.
        scq.delete();
        toq.delete();
        uart_dead = 1'b1;
        feed(0, 8'h55);
        feed(1, 8'h66);
        expect_byte(0, 8'h55);
        expect_byte(1, 8'h66);
        wait_idle("t4", 200);
        uart_dead = 1'b0;
        chk("t4_timeouts", 32'(toq.size()), 32'd2);
        chk("t4_to_delay0", 32'(toq[0] - scq[0]), 32'd16);
        chk("t4_to_delay1", 32'(toq[1] - scq[1]), 32'd16);
        chk("t4_gap", 32'(scq[1] - scq[0]), 32'd18);

        // Reset while waiting for busy to fall in a locked burst.
        uart_len   = 6;
        req_lock_i = 4'b0100;
        feed(2, 8'hC0);
        feed(2, 8'hC1);
        feed(2, 8'hC2);
        expect_byte(2, 8'hC0);
        wait_strobe("t5", 50);
        step(2);
        chk("t5_active_before", 32'(active_o), 32'd1);
        reset_i    = 1'b1;
        req_lock_i = '0;
        phead[2]   = ptail[2];
        step(1);
        chk_all_zero("t5_reset");
        reset_i = 1'b0;
        n0 = nstrobe;
        step(10);
        chk("t5_no_strobe", 32'(nstrobe - n0), 32'd0);
        uart_len = 3;
        feed(3, 8'h33);
        feed(1, 8'h31);
        expect_byte(1, 8'h31);
        expect_byte(3, 8'h33);
        wait_idle("t5_after", 100);

        // Disable mid-burst: the locked message completes, then nothing new starts.
        req_lock_i = 4'b0001;
        feed(0, 8'hE0);
        feed(0, 8'hE1);
        expect_byte(0, 8'hE0);
        expect_byte(0, 8'hE1);
        wait_strobe("t6", 50);
        enable_i = 1'b0;
        n0 = nstrobe;
        feed(1, 8'hA1);
        feed(2, 8'hA2);
        step(40);
        chk("t6_burst_done", 32'(nstrobe - n0), 32'd1);
        chk("t6_idle", 32'(active_o), 32'd0);
        chk("t6_sb_empty", 32'(sbq.size()), 32'd0);
        req_lock_i = '0;
        expect_byte(1, 8'hA1);
        expect_byte(2, 8'hA2);
        enable_i = 1'b1;
        wait_idle("t6_after", 100);

        // Busy high while idle blocks issue.
        busy_force = 1'b1;
        feed(3, 8'h77);
        expect_byte(3, 8'h77);
        n0 = nstrobe;
        step(6);
        chk("t7_blocked", 32'(nstrobe - n0), 32'd0);
        chk("t7_idle", 32'(active_o), 32'd0);
        busy_force = 1'b0;
        wait_idle("t7", 50);
        chk("t7_sent", 32'(nstrobe - n0), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
